// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between I-fill, D-fill and D-store.
// Build option MEM_ARB_ROUND_ROBIN_EN alternates I/D fill priority.
module mem_arbiter #(
  parameter  int ADDR_W  = 16,
  parameter  int DATA_W  = 16,
  parameter  int WORDS   = 8,
  parameter  int MEM_LAT = 4,
  localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] fill_data,
  output logic [IDX_W-1:0]  fill_idx,
  output logic              i_fill_valid,
  output logic              d_fill_valid,
  output logic              i_done,
  output logic              d_done,
  output logic              d_wr_ack,
  output logic              busy
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] BASE_MASK =
    {ADDR_W{1'b1}} << (IDX_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL_I,
    FILL_D
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    iss_q, iss_d;
  logic [IDX_W-1:0]    ret_q, ret_d;
  logic [MEM_LAT-1:0]  vp_q, vp_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                issue;
  logic                ret_v;
  logic                idle;
  logic                pick_d;
  logic                gnt_w, gnt_d, gnt_i;

  assign idle  = (state_q == IDLE);
  assign ret_v = vp_q[MEM_LAT-1];

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_q = 1 when the most recent fill grant went to D
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (gnt_d) last_d = 1'b1;
    else if (gnt_i) last_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b0;
    else        last_q <= last_d;
  end

  assign pick_d = d_req & (~i_req | ~last_q);
`else
  assign pick_d = d_req;
`endif

  assign gnt_w = idle & d_wr_req;
  assign gnt_d = idle & ~d_wr_req & pick_d;
  assign gnt_i = idle & ~d_wr_req & ~pick_d & i_req;

  always_comb begin
    state_d   = state_q;
    iss_d     = iss_q;
    ret_d     = ret_q;
    base_d    = base_q;
    issue     = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    d_wr_ack  = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt_w: state_d = WRITE;
          gnt_d: begin
            state_d = FILL_D;
            base_d  = d_addr & BASE_MASK;
          end
          gnt_i: begin
            state_d = FILL_I;
            base_d  = i_addr & BASE_MASK;
          end
          default: ;
        endcase
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        state_d   = IDLE;
      end
      FILL_I, FILL_D: begin
        if (iss_q < CNT_W'(WORDS)) begin
          issue    = 1'b1;
          mem_en   = 1'b1;
          mem_addr = base_q +
            ADDR_W'({iss_q[IDX_W-1:0], 1'b0});
          iss_d    = iss_q + CNT_W'(1);
        end
        if (ret_v) begin
          ret_d = ret_q + IDX_W'(1);
          if (ret_q == IDX_W'(WORDS - 1)) begin
            i_done  = (state_q == FILL_I);
            d_done  = (state_q == FILL_D);
            state_d = IDLE;
            iss_d   = '0;
            ret_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // valid pipe mirrors the memory latency, one bit per issued read
  assign vp_d = (vp_q << 1) | MEM_LAT'(issue);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iss_q   <= '0;
      ret_q   <= '0;
      vp_q    <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      vp_q    <= vp_d;
      base_q  <= base_d;
    end
  end

  assign fill_data    = mem_rdata;
  assign i_fill_valid = (state_q == FILL_I) & ret_v;
  assign d_fill_valid = (state_q == FILL_D) & ret_v;
  assign fill_idx     = ret_v ? ret_q : '0;
  assign busy         = ~idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a
// fixed-latency memory model and hand-derived cycle timing.
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr_req;
  logic [15:0] d_addr;
  logic [15:0] d_wr_data;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] fill_data;
  logic [2:0]  fill_idx;
  logic        i_fill_valid;
  logic        d_fill_valid;
  logic        i_done;
  logic        d_done;
  logic        d_wr_ack;
  logic        busy;

  int passed = 0;
  int total  = 0;

  mem_arbiter #(
    .ADDR_W (16),
    .DATA_W (16),
    .WORDS  (8),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .d_req       (d_req),
    .d_wr_req    (d_wr_req),
    .d_addr      (d_addr),
    .d_wr_data   (d_wr_data),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .fill_data   (fill_data),
    .fill_idx    (fill_idx),
    .i_fill_valid(i_fill_valid),
    .d_fill_valid(d_fill_valid),
    .i_done      (i_done),
    .d_done      (d_done),
    .d_wr_ack    (d_wr_ack),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mword(input logic [15:0] a);
    logic [15:0] w;
    w = {1'b0, a[15:1]};
    return (w * 16'd7) ^ 16'h5A00;
  endfunction

  // memory: untouched words hold mword(addr), reads return MEM_LAT later
  logic [15:0] wmem [logic [14:0]];
  logic [15:0] rpipe [MEM_LAT];

  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) rpipe[i] = rpipe[i-1];
    rpipe[0] = wmem.exists(mem_addr[15:1]) ?
               wmem[mem_addr[15:1]] : mword(mem_addr);
    if (mem_en && mem_wr) wmem[mem_addr[15:1]] = mem_wdata;
  end

  assign mem_rdata = rpipe[MEM_LAT-1];

  logic        en_r  [32];
  logic        wr_r  [32];
  logic        ifv_r [32];
  logic        dfv_r [32];
  logic        idn_r [32];
  logic        ddn_r [32];
  logic        ack_r [32];
  logic        bsy_r [32];
  logic [15:0] adr_r [32];
  logic [15:0] wd_r  [32];
  logic [15:0] fd_r  [32];
  logic [2:0]  idx_r [32];

  // records cycles 1..n; behaves like the requesters (drop on done/ack)
  task automatic capture(input int n, input int drop_i, input int wr_at);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      en_r[k]  = mem_en;
      wr_r[k]  = mem_wr;
      ifv_r[k] = i_fill_valid;
      dfv_r[k] = d_fill_valid;
      idn_r[k] = i_done;
      ddn_r[k] = d_done;
      ack_r[k] = d_wr_ack;
      bsy_r[k] = busy;
      adr_r[k] = mem_addr;
      wd_r[k]  = mem_wdata;
      fd_r[k]  = fill_data;
      idx_r[k] = fill_idx;
      if (i_done || k == drop_i) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
      if (d_wr_ack) d_wr_req = 1'b0;
      if (k == wr_at) d_wr_req = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wr_req = 1'b0;
    d_addr = '0; d_wr_data = '0;
    #3;
    total++;
    if ({mem_en, mem_wr, i_fill_valid, d_fill_valid, i_done, d_done,
         d_wr_ack, busy, mem_addr, mem_wdata, fill_idx} !== 43'd0)
      $display("FAIL reset_outputs: en=%b wr=%b addr=%h wd=%h idx=%0d busy=%b, want all 0",
               mem_en, mem_wr, mem_addr, mem_wdata, fill_idx, busy);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL reset_idle: busy=%b en=%b, want 0 0", busy, mem_en);
    else passed++;
  endtask

  task automatic test_i_fill();
    logic [15:0] ea;
    i_req = 1'b1; i_addr = 16'h1236;
    capture(14, -1, -1);
    for (int k = 1; k <= 14; k++) begin
      ea = (k <= 8) ? 16'h1230 + 16'(2 * (k - 1)) : 16'h0;
      total++;
      if (en_r[k] !== (k <= 8) || wr_r[k] !== 1'b0 || adr_r[k] !== ea)
        $display("FAIL i_fill_issue c%0d: en=%b wr=%b addr=%h, want %b 0 %h",
                 k, en_r[k], wr_r[k], adr_r[k], k <= 8, ea);
      else passed++;
      total++;
      if (ifv_r[k] !== (k >= 5 && k <= 12) || dfv_r[k] !== 1'b0 ||
          idn_r[k] !== (k == 12) || bsy_r[k] !== (k <= 12))
        $display("FAIL i_fill_flags c%0d: ifv=%b dfv=%b idn=%b busy=%b",
                 k, ifv_r[k], dfv_r[k], idn_r[k], bsy_r[k]);
      else passed++;
      if (k >= 5 && k <= 12) begin
        ea = 16'h1230 + 16'(2 * (k - 5));
        total++;
        if (idx_r[k] !== 3'(k - 5) || fd_r[k] !== mword(ea))
          $display("FAIL i_fill_data c%0d: idx=%0d data=%h, want %0d %h",
                   k, idx_r[k], fd_r[k], k - 5, mword(ea));
        else passed++;
      end
    end
  endtask

  task automatic test_write_readback();
    logic [15:0] ed;
    d_wr_req = 1'b1; d_addr = 16'h0040; d_wr_data = 16'hBEEF;
    capture(2, -1, -1);
    total++;
    if (en_r[1] !== 1'b1 || wr_r[1] !== 1'b1 || adr_r[1] !== 16'h0040 ||
        wd_r[1] !== 16'hBEEF || ack_r[1] !== 1'b1)
      $display("FAIL write_cycle: en=%b wr=%b addr=%h wd=%h ack=%b, want 1 1 0040 beef 1",
               en_r[1], wr_r[1], adr_r[1], wd_r[1], ack_r[1]);
    else passed++;
    total++;
    if (en_r[2] !== 1'b0 || ack_r[2] !== 1'b0 || bsy_r[2] !== 1'b0)
      $display("FAIL write_after: en=%b ack=%b busy=%b, want 0 0 0",
               en_r[2], ack_r[2], bsy_r[2]);
    else passed++;
    d_req = 1'b1; d_addr = 16'h0040;
    capture(13, -1, -1);
    for (int k = 1; k <= 13; k++) begin
      total++;
      if (dfv_r[k] !== (k >= 5 && k <= 12) || ifv_r[k] !== 1'b0 ||
          ddn_r[k] !== (k == 12))
        $display("FAIL readback_flags c%0d: dfv=%b ifv=%b ddn=%b",
                 k, dfv_r[k], ifv_r[k], ddn_r[k]);
      else passed++;
      if (k >= 5 && k <= 12) begin
        ed = (k == 5) ? 16'hBEEF : mword(16'h0040 + 16'(2 * (k - 5)));
        total++;
        if (idx_r[k] !== 3'(k - 5) || fd_r[k] !== ed)
          $display("FAIL readback_data c%0d: idx=%0d data=%h, want %0d %h",
                   k, idx_r[k], fd_r[k], k - 5, ed);
        else passed++;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] a1, a2, ea;
    logic        first_d, f1, f2, en;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    a1 = first_d ? 16'h2000 : 16'h3000;
    a2 = first_d ? 16'h3000 : 16'h2000;
    d_addr = 16'h2000; i_addr = 16'h3008;
    d_req = 1'b1; i_req = 1'b1;
    capture(26, -1, -1);
    for (int k = 1; k <= 26; k++) begin
      en = (k <= 8) || (k >= 14 && k <= 21);
      ea = (k <= 8) ? a1 + 16'(2 * (k - 1)) :
           en ? a2 + 16'(2 * (k - 14)) : 16'h0;
      f1 = (k >= 5 && k <= 12);
      f2 = (k >= 18 && k <= 25);
      total++;
      if (en_r[k] !== en || adr_r[k] !== ea)
        $display("FAIL simul_issue c%0d: en=%b addr=%h, want %b %h",
                 k, en_r[k], adr_r[k], en, ea);
      else passed++;
      total++;
      if (dfv_r[k] !== (first_d ? f1 : f2) ||
          ifv_r[k] !== (first_d ? f2 : f1) ||
          ddn_r[k] !== (first_d ? k == 12 : k == 25) ||
          idn_r[k] !== (first_d ? k == 25 : k == 12) ||
          bsy_r[k] !== (k != 13 && k <= 25))
        $display("FAIL simul_flags c%0d: dfv=%b ifv=%b ddn=%b idn=%b busy=%b",
                 k, dfv_r[k], ifv_r[k], ddn_r[k], idn_r[k], bsy_r[k]);
      else passed++;
      if (f1 || f2) begin
        ea = f1 ? a1 + 16'(2 * (k - 5)) : a2 + 16'(2 * (k - 18));
        total++;
        if (idx_r[k] !== 3'(f1 ? k - 5 : k - 18) || fd_r[k] !== mword(ea))
          $display("FAIL simul_data c%0d: idx=%0d data=%h, want data %h",
                   k, idx_r[k], fd_r[k], mword(ea));
        else passed++;
      end
    end
  endtask

  task automatic test_wr_during_fill();
    logic [15:0] ea;
    logic        en;
    i_req = 1'b1; i_addr = 16'h4000;
    d_addr = 16'h0100; d_wr_data = 16'h1234;
    capture(16, -1, 3);
    for (int k = 1; k <= 16; k++) begin
      en = (k <= 8) || (k == 14);
      ea = (k <= 8) ? 16'h4000 + 16'(2 * (k - 1)) :
           (k == 14) ? 16'h0100 : 16'h0;
      total++;
      if (en_r[k] !== en || adr_r[k] !== ea || wr_r[k] !== (k == 14))
        $display("FAIL wrfill_issue c%0d: en=%b wr=%b addr=%h, want %b %b %h",
                 k, en_r[k], wr_r[k], adr_r[k], en, k == 14, ea);
      else passed++;
      total++;
      if (ifv_r[k] !== (k >= 5 && k <= 12) || idn_r[k] !== (k == 12) ||
          ack_r[k] !== (k == 14) || bsy_r[k] !== (k <= 12 || k == 14))
        $display("FAIL wrfill_flags c%0d: ifv=%b idn=%b ack=%b busy=%b",
                 k, ifv_r[k], idn_r[k], ack_r[k], bsy_r[k]);
      else passed++;
    end
    total++;
    if (wd_r[14] !== 16'h1234)
      $display("FAIL wrfill_wdata: got %h, want 1234", wd_r[14]);
    else passed++;
  endtask

  task automatic test_reset_mid_fill();
    d_req = 1'b1; d_addr = 16'h5000;
    capture(5, -1, -1);
    @(posedge clk);
    #2;
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h500A)
      $display("FAIL rstfill_pre: en=%b addr=%h, want 1 500a", mem_en, mem_addr);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_en, mem_wr, i_fill_valid, d_fill_valid, i_done, d_done,
         d_wr_ack, busy, mem_addr, mem_wdata, fill_idx} !== 43'd0)
      $display("FAIL rstfill_async: en=%b addr=%h dfv=%b ddn=%b busy=%b, want all 0",
               mem_en, mem_addr, d_fill_valid, d_done, busy);
    else passed++;
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    capture(8, -1, -1);
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (dfv_r[k] !== 1'b0 || ddn_r[k] !== 1'b0 || en_r[k] !== 1'b0 ||
          bsy_r[k] !== 1'b0)
        $display("FAIL rstfill_quiet c%0d: dfv=%b ddn=%b en=%b busy=%b, want 0",
                 k, dfv_r[k], ddn_r[k], en_r[k], bsy_r[k]);
      else passed++;
    end
    d_req = 1'b1; d_addr = 16'h5004;
    capture(13, -1, -1);
    total++;
    if (en_r[1] !== 1'b1 || adr_r[1] !== 16'h5000)
      $display("FAIL rstfill_restart: en=%b addr=%h, want 1 5000",
               en_r[1], adr_r[1]);
    else passed++;
    for (int k = 4; k <= 13; k++) begin
      total++;
      if (dfv_r[k] !== (k >= 5 && k <= 12) || ddn_r[k] !== (k == 12))
        $display("FAIL rstfill_flags c%0d: dfv=%b ddn=%b", k, dfv_r[k], ddn_r[k]);
      else passed++;
    end
    total++;
    if (idx_r[5] !== 3'd0 || fd_r[5] !== mword(16'h5000))
      $display("FAIL rstfill_word0: idx=%0d data=%h, want 0 %h",
               idx_r[5], fd_r[5], mword(16'h5000));
    else passed++;
  endtask

  task automatic test_drop_i();
    int nv;
    i_req = 1'b1; i_addr = 16'h6002;
    capture(16, 2, -1);
    nv = 0;
    for (int k = 1; k <= 16; k++) begin
      if (ifv_r[k] === 1'b1) begin
        total++;
        if (idx_r[k] !== 3'(nv) || fd_r[k] !== mword(16'h6000 + 16'(2 * nv)))
          $display("FAIL drop_data c%0d: idx=%0d data=%h, want %0d %h",
                   k, idx_r[k], fd_r[k], nv, mword(16'h6000 + 16'(2 * nv)));
        else passed++;
        nv++;
      end
      total++;
      if (idn_r[k] !== (k == 12) || en_r[k] !== (k <= 8) ||
          bsy_r[k] !== (k <= 12))
        $display("FAIL drop_flags c%0d: idn=%b en=%b busy=%b",
                 k, idn_r[k], en_r[k], bsy_r[k]);
      else passed++;
    end
    total++;
    if (nv != 8)
      $display("FAIL drop_count: got %0d fill words, want 8", nv);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_write_readback();
    test_simultaneous();
    test_wr_during_fill();
    test_reset_mid_fill();
    test_drop_i();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
